oled_spi_byte_responder: RTL
============================

// Module: oled_spi_byte_responder
// PURPOSE
//  Responder end of the send_data / send_data_valid / send_done byte handshake used by the OLED text senders.
//  Accepts one byte per four-phase handshake and shifts it MSB-first to the SSD1306 over SPI mode 3.
//  Drives chip-select and D/C#.
//  Sits between any byte initiator (string sender, init sequencer) and the OLED pins.
// PARAMETERS
//  SCLK_HALF  5  clock cycles per SCLK half-period (100 MHz/(2*5) = 10 MHz); legal range 1..255
//  CS_GAP     2  cycles cs_n held high after the last bit, before send_done rises; legal range 0..255
// PORTS
//  clock            in   1  100 MHz system clock
//  reset_n          in   1  asynchronous, active-low reset
//  send_data        in   8  byte to transmit; sampled only at acceptance
//  send_dc_n        in   1  D/C# for this byte (0 = command, 1 = data); sampled at acceptance
//  send_data_valid  in   1  initiator request; held high until send_done seen
//  send_done        out  1  byte complete; held until send_data_valid low
//  busy             out  1  high from acceptance until return to IDLE
//  oled_spi_clk     out  1  SCLK, idles high (CPOL=1)
//  oled_spi_data    out  1  MOSI; changes on SCLK falling edge, stable on rising edge
//  oled_spi_cs_n    out  1  chip select, active low
//  oled_dc_n        out  1  registered D/C# for the byte in flight
// BEHAVIOUR
//  Reset values (asserted asynchronously, immediately):
//   - oled_spi_clk=1, oled_spi_cs_n=1, oled_spi_data=0, oled_dc_n=1
//   - send_done=0, busy=0, state=IDLE
//  All outputs are registered.
//  States:
//   - IDLE: waits for send_data_valid=1. On that edge it latches send_data and send_dc_n, sets
//     cs_n=0, oled_dc_n=latched value, MOSI=bit7, SCLK=1, busy=1, then goes to SETUP.
//   - SETUP: SCLK high for SCLK_HALF cycles (cs-to-clock setup), then goes to SHIFT.
//   - SHIFT: 8 bits, bit7 first. Each bit is SCLK low for SCLK_HALF cycles, then high for SCLK_HALF.
//     MOSI updates to the next bit on the same edge SCLK falls (bit7 is already driven).
//     After the 8th high phase: cs_n=1, SCLK stays 1, go to GAP.
//   - GAP: cs_n high for CS_GAP cycles (skipped if 0), then DONE with send_done=1.
//   - DONE: holds send_done=1 while send_data_valid=1. On the first cycle it samples valid=0:
//     send_done=0, busy=0, go to IDLE.
//  Latency: send_done rises 17*SCLK_HALF+CS_GAP+1 cycles after the accepting edge (88 at defaults).
//  Handshake rules:
//   - No new byte is accepted while send_done=1; a fresh byte needs valid low-then-high.
//   - If valid drops during SETUP/SHIFT/GAP, the byte still completes. send_done is then a
//     one-cycle pulse, because DONE sees valid=0.
//   - send_data/send_dc_n changes after acceptance are ignored.
//  Counters: bit counter 3 bits, wraps 7->0 only as the SHIFT exit; half-period counter
//   8 bits, reload SCLK_HALF-1.
//  Reset mid-byte: the transfer is aborted, cs_n deasserts immediately, no send_done is produced.
//   The slave discards the partial byte on cs_n rise.
// STRUCTURE
//  Package oled_pkg:
//   - state enum {IDLE, SETUP, SHIFT, GAP, DONE}
//   - SCLK_HALF_DEF=5, CS_GAP_DEF=2, OLED_CMD=1'b0, OLED_DATA=1'b1
//  One sub-module, oled_spi_clk_div:
//   - half-period tick generator
//   - enable input, restarts on enable rise
//   - tick output every SCLK_HALF cycles
//  The FSM, shift register and bit counter stay in this module.
// TESTING
//  1. Reset: hold reset_n=0 mid-SHIFT -> next sample shows cs_n=1, SCLK=1, send_done=0, busy=0.
//  2. Single byte: send_data=8'hA5, send_dc_n=1, valid=1.
//     -> MOSI sampled on 8 SCLK rises = 1,0,1,0,0,1,0,1.
//     -> oled_dc_n=1 throughout; send_done rises exactly 88 cycles after the accept edge.
//  3. Command byte: 8'hAF, send_dc_n=0 -> oled_dc_n=0 while cs_n=0; 8 rising edges, never 7 or 9.
//  4. Held handshake: keep valid=1 for 20 cycles after send_done.
//     -> send_done stays 1 and no second transfer starts.
//     -> Drop valid: send_done=0 the next cycle; re-raise valid: new byte accepted.
//  5. Early release: drop valid 10 cycles after acceptance -> byte completes, send_done high exactly 1 cycle.
//  6. String run: drive "Hello world" (11 bytes) through the four-phase initiator.
//     -> Scoreboard sees 48 65 6C 6C 6F 20 77 6F 72 6C 64 in order.
//     -> cs_n high >= CS_GAP cycles between bytes.
//     -> SCLK period 10 cycles; repeat with SCLK_HALF=1 and CS_GAP=0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and defaults for the OLED SPI byte responder.
package oled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } oled_state_e;

    localparam int unsigned SCLK_HALF_DEF = 5;
    localparam int unsigned CS_GAP_DEF    = 2;
    localparam logic        OLED_CMD      = 1'b0;
    localparam logic        OLED_DATA     = 1'b1;

endpackage

// File: rtl/oled_spi_clk_div.sv
// SCLK half-period tick generator; restarts its count whenever enable rises.
module oled_spi_clk_div
    import oled_pkg::*;
#(
    parameter int unsigned SCLK_HALF = SCLK_HALF_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(SCLK_HALF - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       en_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RELOAD;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= enable_i;
        end
    end

    // The enable-rise cycle only reloads; counting starts the cycle after.
    always_comb begin
        tick_o = 1'b0;
        cnt_d  = RELOAD;
        if (enable_i && en_q) begin
            if (cnt_q == '0) begin
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

endmodule

// File: rtl/oled_spi_byte_responder.sv
// Byte handshake responder: shifts one accepted byte MSB-first to the SSD1306 over SPI mode 3.
module oled_spi_byte_responder
    import oled_pkg::*;
#(
    parameter int unsigned SCLK_HALF = SCLK_HALF_DEF,
    parameter int unsigned CS_GAP    = CS_GAP_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] send_data,
    input  logic       send_dc_n,
    input  logic       send_data_valid,
    output logic       send_done,
    output logic       busy,
    output logic       oled_spi_clk,
    output logic       oled_spi_data,
    output logic       oled_spi_cs_n,
    output logic       oled_dc_n
);

    localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

    oled_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  gap_q, gap_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        csn_q, csn_d;
    logic        dcn_q, dcn_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic        last_edge;

    oled_spi_clk_div #(
        .SCLK_HALF(SCLK_HALF)
    ) u_clk_div (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .enable_i((state_q == SETUP) || (state_q == SHIFT)),
        .tick_o  (tick)
    );

    assign last_edge = tick && sclk_q && (bit_q == 3'd7);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            dcn_q   <= OLED_DATA;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            dcn_q   <= dcn_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (send_data_valid) state_d = SETUP;
            SETUP:   if (tick) state_d = SHIFT;
            SHIFT:   if (last_edge) state_d = (CS_GAP == 0) ? DONE : GAP;
            GAP:     if (gap_q == '0) state_d = DONE;
            DONE:    if (!send_data_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        dcn_d   = dcn_q;
        done_d  = done_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (send_data_valid) begin
                    shreg_d = send_data;
                    dcn_d   = send_dc_n;
                    csn_d   = 1'b0;
                    mosi_d  = send_data[7];
                    sclk_d  = 1'b1;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    bit_d  = '0;
                end
            end
            SHIFT: begin
                // Falling edge advances MOSI; bit7 was driven at acceptance.
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 3'd7) begin
                        csn_d  = 1'b1;
                        bit_d  = '0;
                        gap_d  = GAP_RELOAD;
                        done_d = (CS_GAP == 0);
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                        mosi_d  = shreg_q[6];
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    done_d = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            DONE: begin
                if (!send_data_valid) begin
                    done_d = 1'b0;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign send_done     = done_q;
    assign busy          = busy_q;
    assign oled_spi_clk  = sclk_q;
    assign oled_spi_data = mosi_q;
    assign oled_spi_cs_n = csn_q;
    assign oled_dc_n     = dcn_q;

endmodule
